song_sequencer: RTL and testbench
=================================

# song_sequencer

Parametrised auto-play note sequencer that walks a multi-song note store and drives the buzzer, octave and LED paths in auto mode. It generalises song count, song depth, note/duration widths and tick rate. It reads a synchronous one-cycle-latency song ROM and adds pause, loop/one-shot modes, an end-of-song pulse and glitch-free note hand-over. It sits between the song library and the buzzer/LED/seven-segment drivers.

## Interface
- SONG_COUNT, 3, number of songs; song index wraps 0..SONG_COUNT-1
- SONG_DEPTH, 64, max entries per song
- TICKS_PER_UNIT, 10_000_000, clk cycles per duration unit
- NOTE_W, 4, note code width
- DUR_W, 4, duration field width (units)
- END_CODE, 4'hF, note code marking end of song
- SONG_W = max(1,clog2(SONG_COUNT)); POS_W = clog2(SONG_DEPTH) (derived)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- next_sel  in  1  level; rising edge selects next song
- prev_sel  in  1  level; rising edge selects previous song
- pause  in  1  level; high freezes playback
- loop_en  in  1  1 = restart song at end, 0 = stop at end
- rom_song  out  SONG_W  registered song index to ROM
- rom_pos  out  POS_W  registered entry index to ROM
- rom_data  in  DUR_W+2+NOTE_W  {dur, octave, note}, valid one cycle after address
- note_out  out  NOTE_W  note to buzzer; 0 = rest
- octave_out  out  2  octave of current note
- led_out  out  7  one-hot LED for notes 1..7, else 0
- song_num  out  SONG_W  current song index
- playing  out  1  high in PLAY with pause low
- song_done  out  1  one-cycle pulse on end of song

## Operation
- States: FETCH, LATCH, PLAY, DONE. Reset -> FETCH, song 0, pos 0.
- FETCH: rom_song/rom_pos hold {song_num,pos}; -> LATCH next cycle.
- LATCH: capture rom_data. If note == END_CODE or captured entry is invalid: end-of-song. Else load note/octave/LED outputs, load counter with max(dur,1)*TICKS_PER_UNIT-1, -> PLAY.
- PLAY: counter decrements each cycle unless pause. At 0: if pos == SONG_DEPTH-1 -> end-of-song; else pos+1 -> FETCH.
- End-of-song: song_done pulses 1 cycle; loop_en=1 -> pos 0, FETCH; loop_en=0 -> DONE with outputs silenced (note 0, LED 0, octave 0).
- DONE: holds until a song-select edge.
- Song select: edge detect via history registers (reset to 0; a line held high through reset yields one edge on first cycle after release). next_sel has priority if both edges coincide. next: SONG_COUNT-1 -> 0 wrap; prev: 0 -> SONG_COUNT-1 wrap. On edge in any state: song_num updates, pos 0, outputs silenced, counter cleared, -> FETCH; no song_done.
- Pause: counter and state frozen in PLAY; note_out and led_out forced 0, octave_out held; release resumes with remaining count. Pause in FETCH/LATCH lets fetch complete, then freezes in PLAY. Song select is honoured while paused.
- Duration arithmetic: product computed at width clog2(2^DUR_W*TICKS_PER_UNIT); dur 0 treated as 1.
- Reset mid-note: all outputs and state return to reset values immediately.

## Timing
- Reset values: note_out 0, octave_out 0, led_out 0, song_num 0, rom_song 0, rom_pos 0, playing 0, song_done 0.
- Per note: 2 overhead cycles (FETCH, LATCH) + dur*TICKS_PER_UNIT PLAY cycles; previous note outputs held through overhead (no rest glitch between consecutive notes).
- First note after reset/song change: outputs 0 for the 2 overhead cycles.
- Outputs change on the clock edge leaving LATCH; song_done asserted in the cycle after the LATCH/PLAY cycle detecting end.
- Song-select edge registered: song_num changes 1 cycle after the input rises.

## Test plan
- Reset, TICKS_PER_UNIT=4, song 0 = {n1 d2, n3 d1, END}, loop_en=1 -> note 1 for 8 cycles, note 3 for 4, song_done pulse, note 1 again; led_out 0000001 then 0000100.
- Same song, loop_en=0 -> after note 3, song_done once, DONE, all outputs 0 indefinitely; next_sel edge -> song 1 starts.
- next_sel at song 2 -> song 0; prev_sel at song 0 -> song 2; both edges same cycle -> next wins.
- pause 3 cycles mid note (dur 2) -> note_out/led_out 0 during pause, note resumes, total PLAY cycles still 8.
- Entry with dur 0 -> plays 4 cycles; song of SONG_DEPTH entries without END -> wraps/stops after last entry with song_done.
- Async reset asserted mid-note between clock edges -> outputs 0 immediately; next_sel held high through reset -> one song advance after release.

Source files
------------

// File: rtl/song_sequencer.sv
// Auto-play note sequencer: walks a song ROM entry by entry and drives the
// buzzer note, octave and LED outputs, with pause, looping and song select.
module song_sequencer #(
    parameter int SONG_COUNT     = 3,
    parameter int SONG_DEPTH     = 64,
    parameter int TICKS_PER_UNIT = 10_000_000,
    parameter int NOTE_W         = 4,
    parameter int DUR_W          = 4,
    parameter logic [NOTE_W-1:0] END_CODE = NOTE_W'(4'hF),
    localparam int SONG_W = (SONG_COUNT > 1) ? $clog2(SONG_COUNT) : 1,
    localparam int POS_W  = $clog2(SONG_DEPTH),
    localparam int ROM_W  = DUR_W + 2 + NOTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              next_sel,
    input  logic              prev_sel,
    input  logic              pause,
    input  logic              loop_en,
    output logic [SONG_W-1:0] rom_song,
    output logic [POS_W-1:0]  rom_pos,
    input  logic [ROM_W-1:0]  rom_data,
    output logic [NOTE_W-1:0] note_out,
    output logic [1:0]        octave_out,
    output logic [6:0]        led_out,
    output logic [SONG_W-1:0] song_num,
    output logic              playing,
    output logic              song_done
);

    localparam int CNT_W = $clog2((2 ** DUR_W) * TICKS_PER_UNIT);
    localparam logic [CNT_W-1:0] TICKS = CNT_W'(TICKS_PER_UNIT);

    typedef enum logic [1:0] {FETCH, LATCH, PLAY, DONE} state_t;

    state_t            state, state_nx;
    logic [SONG_W-1:0] song, song_nx;
    logic [POS_W-1:0]  pos, pos_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [NOTE_W-1:0] note, note_nx;
    logic [1:0]        octave, octave_nx;
    logic [6:0]        led, led_nx;
    logic              done, done_nx;
    logic              next_hist, prev_hist;
    logic              next_edge, prev_edge;
    logic              end_song;
    logic              paused;

    logic [NOTE_W-1:0] rom_note;
    logic [1:0]        rom_oct;
    logic [DUR_W-1:0]  rom_dur;
    logic [DUR_W-1:0]  dur_eff;
    logic [CNT_W-1:0]  load_val;
    logic [6:0]        led_dec;

    assign {rom_dur, rom_oct, rom_note} = rom_data;
    assign dur_eff   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
    assign load_val  = CNT_W'(dur_eff) * TICKS - CNT_W'(1);
    assign next_edge = next_sel & ~next_hist;
    assign prev_edge = prev_sel & ~prev_hist;

    always_comb begin
        led_dec = '0;
        for (int i = 0; i < 7; i++) begin
            led_dec[i] = (rom_note == NOTE_W'(i + 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FETCH;
            song      <= '0;
            pos       <= '0;
            count     <= '0;
            note      <= '0;
            octave    <= '0;
            led       <= '0;
            done      <= 1'b0;
            next_hist <= 1'b0;
            prev_hist <= 1'b0;
        end else begin
            state     <= state_nx;
            song      <= song_nx;
            pos       <= pos_nx;
            count     <= count_nx;
            note      <= note_nx;
            octave    <= octave_nx;
            led       <= led_nx;
            done      <= done_nx;
            next_hist <= next_sel;
            prev_hist <= prev_sel;
        end
    end

    // A song-select edge overrides everything, including a coincident end of song.
    always_comb begin
        state_nx  = state;
        song_nx   = song;
        pos_nx    = pos;
        count_nx  = count;
        note_nx   = note;
        octave_nx = octave;
        led_nx    = led;
        done_nx   = 1'b0;
        end_song  = 1'b0;
        if (next_edge || prev_edge) begin
            if (next_edge) begin
                song_nx = (song == SONG_W'(SONG_COUNT - 1)) ? '0 : song + SONG_W'(1);
            end else begin
                song_nx = (song == '0) ? SONG_W'(SONG_COUNT - 1) : song - SONG_W'(1);
            end
            pos_nx    = '0;
            count_nx  = '0;
            note_nx   = '0;
            octave_nx = '0;
            led_nx    = '0;
            state_nx  = FETCH;
        end else begin
            unique case (state)
                FETCH: state_nx = LATCH;
                LATCH: begin
                    if (rom_note == END_CODE) begin
                        end_song = 1'b1;
                    end else begin
                        note_nx   = rom_note;
                        octave_nx = rom_oct;
                        led_nx    = led_dec;
                        count_nx  = load_val;
                        state_nx  = PLAY;
                    end
                end
                PLAY: begin
                    if (!pause) begin
                        if (count == '0) begin
                            if (pos == POS_W'(SONG_DEPTH - 1)) begin
                                end_song = 1'b1;
                            end else begin
                                pos_nx   = pos + POS_W'(1);
                                state_nx = FETCH;
                            end
                        end else begin
                            count_nx = count - CNT_W'(1);
                        end
                    end
                end
                DONE: state_nx = DONE;
            endcase
            if (end_song) begin
                done_nx = 1'b1;
                pos_nx  = '0;
                if (loop_en) begin
                    state_nx = FETCH;
                end else begin
                    state_nx  = DONE;
                    note_nx   = '0;
                    octave_nx = '0;
                    led_nx    = '0;
                end
            end
        end
    end

    // Pause mutes the buzzer and LEDs but keeps the octave display.
    assign paused     = (state == PLAY) && pause;
    assign note_out   = paused ? '0 : note;
    assign led_out    = paused ? '0 : led;
    assign octave_out = octave;
    assign playing    = (state == PLAY) && !pause;
    assign song_done  = done;
    assign song_num   = song;
    assign rom_song   = song;
    assign rom_pos    = pos;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: vector table for the basic song,
// directed corner cases, then random stimulus against a behavioural model.
module tb_song_sequencer;

    localparam int SONGS = 3;
    localparam int DEPTH = 4;
    localparam int TICKS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       next_sel = 1'b0;
    logic       prev_sel = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] rom_song;
    logic [1:0] rom_pos;
    logic [9:0] rom_data = '0;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [1:0] song_num;
    logic       playing;
    logic       song_done;

    logic [9:0] rom_mem [0:SONGS-1][0:DEPTH-1];

    int vectors = 0;
    int miscompares = 0;

    song_sequencer #(
        .SONG_COUNT(SONGS), .SONG_DEPTH(DEPTH), .TICKS_PER_UNIT(TICKS),
        .NOTE_W(4), .DUR_W(4), .END_CODE(4'hF)
    ) dut (
        .clk(clk), .reset(reset), .next_sel(next_sel), .prev_sel(prev_sel),
        .pause(pause), .loop_en(loop_en), .rom_song(rom_song), .rom_pos(rom_pos),
        .rom_data(rom_data), .note_out(note_out), .octave_out(octave_out),
        .led_out(led_out), .song_num(song_num), .playing(playing), .song_done(song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_song][rom_pos];

    function automatic logic [9:0] ent(input int d, input int o, input int n);
        return {4'(d), 2'(o), 4'(n)};
    endfunction

    // Behavioural model: counts overhead and play cycles per note.
    int m_song, m_pos, m_wait, m_left, m_note, m_oct;
    bit m_stopped, m_done, m_next_h, m_prev_h;

    task automatic model_reset();
        m_song = 0; m_pos = 0; m_wait = 2; m_left = 0; m_note = 0; m_oct = 0;
        m_stopped = 0; m_done = 0; m_next_h = 0; m_prev_h = 0;
    endtask

    task automatic model_end();
        m_done = 1;
        m_pos = 0;
        if (loop_en) begin
            m_wait = 2;
        end else begin
            m_stopped = 1;
            m_note = 0;
            m_oct = 0;
        end
    endtask

    task automatic model_step();
        bit ne, pe;
        logic [9:0] e;
        int d;
        ne = next_sel && !m_next_h;
        pe = prev_sel && !m_prev_h;
        m_next_h = next_sel;
        m_prev_h = prev_sel;
        m_done = 0;
        if (ne || pe) begin
            m_song = ne ? (m_song + 1) % SONGS : (m_song + SONGS - 1) % SONGS;
            m_pos = 0; m_wait = 2; m_left = 0; m_stopped = 0; m_note = 0; m_oct = 0;
        end else if (!m_stopped) begin
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    e = rom_mem[m_song][m_pos];
                    if (e[3:0] == 4'hF) begin
                        model_end();
                    end else begin
                        m_note = int'(e[3:0]);
                        m_oct = int'(e[5:4]);
                        d = int'(e[9:6]);
                        if (d == 0) d = 1;
                        m_left = d * TICKS;
                    end
                end
            end else if (!pause) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_pos == DEPTH - 1) begin
                        model_end();
                    end else begin
                        m_pos++;
                        m_wait = 2;
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit n, input bit p, input bit pa, input bit le);
        next_sel = n;
        prev_sel = p;
        pause = pa;
        loop_en = le;
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name);
        bit in_play;
        logic [3:0] e_note;
        logic [6:0] e_led;
        logic [1:0] e_oct, e_song, e_pos;
        logic e_play, e_done;
        in_play = !m_stopped && (m_wait == 0);
        e_note = (in_play && pause) ? 4'd0 : 4'(m_note);
        e_led = (e_note >= 4'd1 && e_note <= 4'd7) ? 7'(1 << (int'(e_note) - 1)) : 7'd0;
        e_oct = 2'(m_oct);
        e_song = 2'(m_song);
        e_pos = 2'(m_pos);
        e_play = in_play && !pause;
        e_done = m_done;
        vectors++;
        if (note_out !== e_note || led_out !== e_led || octave_out !== e_oct ||
            song_num !== e_song || rom_pos !== e_pos || playing !== e_play ||
            song_done !== e_done) begin
            miscompares++;
            $display("[TB] FAIL %s: got note=%0d oct=%0d led=%b song=%0d pos=%0d play=%b done=%b, expected note=%0d oct=%0d led=%b song=%0d pos=%0d play=%b done=%b",
                     name, note_out, octave_out, led_out, song_num, rom_pos, playing, song_done,
                     e_note, e_oct, e_led, e_song, e_pos, e_play, e_done);
        end
    endtask

    task automatic check_val(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulse_sel(input bit n, input bit p, input int exp_song, input string name);
        applyStimulus(n, p, 1'b0, 1'b1);
        check_val(name, int'(song_num), exp_song);
        checkOutput(name);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput(name);
    endtask

    task automatic do_reset();
        next_sel = 0; prev_sel = 0; pause = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        checkOutput("reset_values");
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] cycles;
        logic       pause;
        logic       loop_en;
        logic [3:0] note;
        logic [1:0] oct;
        logic [6:0] led;
        logic       playing;
        logic       done;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int cnt, done_cnt, n5_cnt;
        bit brk;

        tbl[0]  = '{8'd1, 1'b0, 1'b1, 4'd0, 2'd0, 7'b0000000, 1'b0, 1'b0};
        tbl[1]  = '{8'd8, 1'b0, 1'b1, 4'd1, 2'd1, 7'b0000001, 1'b1, 1'b0};
        tbl[2]  = '{8'd2, 1'b0, 1'b1, 4'd1, 2'd1, 7'b0000001, 1'b0, 1'b0};
        tbl[3]  = '{8'd4, 1'b0, 1'b1, 4'd3, 2'd2, 7'b0000100, 1'b1, 1'b0};
        tbl[4]  = '{8'd2, 1'b0, 1'b1, 4'd3, 2'd2, 7'b0000100, 1'b0, 1'b0};
        tbl[5]  = '{8'd1, 1'b0, 1'b1, 4'd3, 2'd2, 7'b0000100, 1'b0, 1'b1};
        tbl[6]  = '{8'd1, 1'b0, 1'b1, 4'd3, 2'd2, 7'b0000100, 1'b0, 1'b0};
        tbl[7]  = '{8'd8, 1'b0, 1'b1, 4'd1, 2'd1, 7'b0000001, 1'b1, 1'b0};
        tbl[8]  = '{8'd2, 1'b0, 1'b0, 4'd1, 2'd1, 7'b0000001, 1'b0, 1'b0};
        tbl[9]  = '{8'd4, 1'b0, 1'b0, 4'd3, 2'd2, 7'b0000100, 1'b1, 1'b0};
        tbl[10] = '{8'd2, 1'b0, 1'b0, 4'd3, 2'd2, 7'b0000100, 1'b0, 1'b0};
        tbl[11] = '{8'd1, 1'b0, 1'b0, 4'd0, 2'd0, 7'b0000000, 1'b0, 1'b1};
        tbl[12] = '{8'd5, 1'b0, 1'b0, 4'd0, 2'd0, 7'b0000000, 1'b0, 1'b0};

        rom_mem[0][0] = ent(2, 1, 1);  rom_mem[0][1] = ent(1, 2, 3);
        rom_mem[0][2] = ent(0, 0, 15); rom_mem[0][3] = ent(1, 0, 2);
        rom_mem[1][0] = ent(0, 0, 5);  rom_mem[1][1] = ent(1, 3, 2);
        rom_mem[1][2] = ent(1, 1, 9);  rom_mem[1][3] = ent(1, 2, 7);
        rom_mem[2][0] = ent(1, 0, 0);  rom_mem[2][1] = ent(3, 1, 4);
        rom_mem[2][2] = ent(0, 0, 15); rom_mem[2][3] = ent(1, 1, 1);

        loop_en = 1'b1;
        do_reset();

        for (int k = 0; k < 13; k++) begin
            for (int c = 0; c < int'(tbl[k].cycles); c++) begin
                applyStimulus(1'b0, 1'b0, tbl[k].pause, tbl[k].loop_en);
                vectors++;
                if (note_out !== tbl[k].note || octave_out !== tbl[k].oct ||
                    led_out !== tbl[k].led || playing !== tbl[k].playing ||
                    song_done !== tbl[k].done || song_num !== 2'd0) begin
                    miscompares++;
                    $display("[TB] FAIL table[%0d] cycle %0d: got note=%0d oct=%0d led=%b play=%b done=%b song=%0d, expected note=%0d oct=%0d led=%b play=%b done=%b song=0",
                             k, c, note_out, octave_out, led_out, playing, song_done, song_num,
                             tbl[k].note, tbl[k].oct, tbl[k].led, tbl[k].playing, tbl[k].done);
                end
            end
        end

        // Song 1 from DONE: zero-duration first entry, no END code.
        done_cnt = 0;
        n5_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i < 3, 1'b0, 1'b0, 1'b0);
            if (i == 0) check_val("sel_next_latency", int'(song_num), 1);
            checkOutput("song1_run");
            if (song_done) done_cnt++;
            if (playing && note_out == 4'd5) n5_cnt++;
        end
        check_val("dur0_cycles", n5_cnt, 4);
        check_val("depth_end_done", done_cnt, 1);
        check_val("depth_end_silent", int'({note_out, led_out, octave_out, playing}), 0);

        pulse_sel(1'b1, 1'b0, 2, "next_1_to_2");
        pulse_sel(1'b1, 1'b0, 0, "next_wrap_2_to_0");
        pulse_sel(1'b0, 1'b1, 2, "prev_wrap_0_to_2");
        pulse_sel(1'b1, 1'b1, 0, "both_next_wins");

        // Pause three cycles inside note 1 of song 0.
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("pre_pause");
            if (playing && note_out == 4'd1) cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            check_val("pause_mute", int'({note_out, led_out, playing}), 0);
            check_val("pause_oct_held", int'(octave_out), 1);
            checkOutput("pause");
        end
        brk = 0;
        for (int i = 0; i < 20 && !brk; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("post_pause");
            if (playing && note_out == 4'd1) cnt++;
            else brk = 1;
        end
        check_val("pause_total_play", cnt, 8);

        // Async reset mid-note with next_sel held high through it.
        pulse_sel(1'b1, 1'b0, 1, "next_0_to_1");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput("pre_async_reset");
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        next_sel = 1'b1;
        #1;
        check_val("async_reset_outputs",
                  int'({note_out, led_out, octave_out, song_num, rom_pos, playing, song_done}), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        check_val("held_sel_one_advance", int'(song_num), 1);
        checkOutput("held_sel");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput("held_sel_hold");
        end

        // Random ROM contents and random controls against the model.
        for (int s = 0; s < SONGS; s++) begin
            for (int p = 0; p < DEPTH; p++) begin
                rom_mem[s][p] = ent($urandom_range(0, 3), $urandom_range(0, 3),
                                    ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 14));
            end
        end
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 4) == 0, loop_en);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
